hazard_scheduler: RTL
=====================

HAZARD_SCHEDULER -- requirements
Module: hazard_scheduler

Interface
REQ-001 SHALL have parameter TICK_CYCLES, default 4, meaning clk cycles per pattern step (legal range 1..2^26-1; board builds use 37_500_000).
REQ-002 SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = reset asserted).
REQ-004 SHALL have port mode_req, input, 2 bits: requested pattern from switches, asynchronous to clk; 00 calm, 01 left-to-right, 10 right-to-left, 11 illegal.
REQ-005 SHALL have port pause, input, 1 bit: synchronous; 1 freezes the prescaler and the step sequence.
REQ-006 SHALL have port lamps, output, 3 bits: lamp drive, bit 2 = left, bit 0 = right.
REQ-007 SHALL have port mode_cur, output, 2 bits: pattern currently displayed.
REQ-008 SHALL have port tick, output, 1 bit: one-cycle pulse marking each step edge.
REQ-009 SHALL have port change_pending, output, 1 bit: synchronized request differs from mode_cur while in RUN.

Function
REQ-010 SHALL pass mode_req through a 2-flop synchronizer; mode_sync is the second-stage value, so latency is 2 clk edges.
REQ-011 SHALL map mode_sync = 11 to 00 (calm) wherever it is loaded into mode_cur.
REQ-012 SHALL implement a prescaler counting 0..TICK_CYCLES-1; when the count is TICK_CYCLES-1 and pause = 0, the next edge wraps it to 0 and registers tick = 1 for exactly one cycle.
REQ-013 SHALL hold the prescaler count and keep tick = 0 while pause = 1; counting resumes from the held value.
REQ-014 SHALL implement FSM states IDLE and RUN with a step index; pattern length is 2 for calm and 3 for the directional modes.
REQ-015 SHALL use these step patterns (step 0 first): calm 101, 010; left-to-right 100, 010, 001; right-to-left 001, 010, 100.
REQ-016 SHALL update lamps on the same edge that tick rises, so lamps and tick change together.
REQ-017 SHALL, in IDLE, hold lamps = 000 and mode_cur = 00; on the first tick go to RUN, load mode_cur from mode_sync (per REQ-011), set step = 0 and drive pattern step 0.
REQ-018 SHALL, in RUN on a tick with step < last, increment step and drive the next pattern of the unchanged mode_cur.
REQ-019 SHALL, in RUN on a tick with step = last, load mode_cur from mode_sync (per REQ-011), set step = 0 and drive step 0 of the newly loaded mode, so mode changes take effect only at pattern boundaries.
REQ-020 SHALL ignore mode_sync changes between boundary ticks; only the value present on the boundary tick is used.
REQ-021 SHALL have a request that toggles away and back before a boundary cause no mode change.
REQ-022 SHALL drive change_pending = 0 in IDLE; in RUN it equals (mapped mode_sync != mode_cur), combinational from registered state.
REQ-023 SHALL keep lamps exactly one-hot or 101/010 in RUN; lamps = 000 occurs only in IDLE.
REQ-024 SHALL, with TICK_CYCLES = 1, assert tick every cycle and advance one step per cycle.
REQ-025 SHALL, when pause and a boundary coincide, not produce the tick, so no step advance or mode load occurs until pause releases.

Reset
REQ-026 SHALL, on reset = 0, asynchronously force state IDLE, step 0, prescaler 0, both synchronizer flops 00, lamps 000, mode_cur 00 and tick 0.
REQ-027 SHALL, on reset asserted mid-pattern, abandon the pattern; after release the first tick occurs TICK_CYCLES edges later and starts from IDLE rules (REQ-017).
REQ-028 SHALL release reset synchronously to clk; the first count occurs on the first edge with reset = 1.

Verification (TICK_CYCLES = 4)
REQ-029 SHALL verify that after reset release with mode_req = 00 held, tick pulses every 4 cycles, and lamps go 000 -> 101 -> 010 -> 101 with mode_cur = 00.
REQ-030 SHALL verify that with mode_req = 01 held from reset, lamps go 100, 010, 001, 100, with a tick each step.
REQ-031 SHALL verify that with mode_req switched 01 -> 10 while lamps = 010 (left-to-right), change_pending rises 2 cycles later, lamps reach 001, and then 001 at the next boundary is right-to-left step 0 with mode_cur = 10 and change_pending = 0.
REQ-032 SHALL verify that mode_req = 11 yields calm patterns and mode_cur = 00.
REQ-033 SHALL verify that pause = 1 for 10 cycles mid-pattern gives no tick and holds lamps, and that the sequence resumes from the held prescaler value.
REQ-034 SHALL verify that reset asserted while lamps = 001 immediately gives lamps = 000 and mode_cur = 00, and that the first tick after release occurs 4 edges later.

Source files
------------

// File: rtl/hazard_scheduler.sv
// Hazard-lamp pattern scheduler: a prescaled step clock drives calm or directional
// lamp patterns. A requested mode change takes effect only at a pattern boundary.
module hazard_scheduler #(
    parameter int TICK_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] mode_req,
    input  logic       pause,
    output logic [2:0] lamps,
    output logic [1:0] mode_cur,
    output logic       tick,
    output logic       change_pending,
    output logic       fsm_state
);

    localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_CYCLES - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic [1:0]    sync1, sync2;
    logic [1:0]    mode_legal;
    logic [1:0]    step, step_nxt;
    logic [1:0]    mode_nxt;
    logic [2:0]    lamps_nxt;
    logic          step_edge;

    function automatic logic [2:0] pattern(input logic [1:0] m, input logic [1:0] s);
        logic [2:0] p;
        case (m)
            2'b01:   p = (s == 2'd0) ? 3'b100 : (s == 2'd1) ? 3'b010 : 3'b001;
            2'b10:   p = (s == 2'd0) ? 3'b001 : (s == 2'd1) ? 3'b010 : 3'b100;
            default: p = (s == 2'd0) ? 3'b101 : 3'b010;
        endcase
        return p;
    endfunction

    function automatic logic [1:0] last_step(input logic [1:0] m);
        return (m == 2'b01 || m == 2'b10) ? 2'd2 : 2'd1;
    endfunction

    // The illegal request 11 is treated as calm.
    assign mode_legal = (sync2 == 2'b11) ? 2'b00 : sync2;
    assign step_edge  = !pause && (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 2'b00;
            sync2 <= 2'b00;
        end else begin
            sync1 <= mode_req;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= step_edge;
            if (!pause) begin
                cnt <= step_edge ? '0 : cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            step     <= 2'd0;
            mode_cur <= 2'b00;
            lamps    <= 3'b000;
        end else begin
            state    <= state_nxt;
            step     <= step_nxt;
            mode_cur <= mode_nxt;
            lamps    <= lamps_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        step_nxt  = step;
        mode_nxt  = mode_cur;
        lamps_nxt = lamps;
        if (step_edge) begin
            case (state)
                S_IDLE: begin
                    state_nxt = S_RUN;
                    mode_nxt  = mode_legal;
                    step_nxt  = 2'd0;
                    lamps_nxt = pattern(mode_legal, 2'd0);
                end
                default: begin
                    // Only a boundary step may pick up a new mode.
                    if (step == last_step(mode_cur)) begin
                        mode_nxt  = mode_legal;
                        step_nxt  = 2'd0;
                        lamps_nxt = pattern(mode_legal, 2'd0);
                    end else begin
                        step_nxt  = step + 2'd1;
                        lamps_nxt = pattern(mode_cur, step + 2'd1);
                    end
                end
            endcase
        end
    end

    assign change_pending = (state == S_RUN) && (mode_legal != mode_cur);
    assign fsm_state      = (state == S_RUN);

endmodule
